twiddle_mult_stage: RTL and testbench

//  Complex twiddle multiplier between FFT butterfly stages of the 64-point FFT.

---
 rtl/fft_pkg.sv | 46 ++++
 rtl/twiddle_rom_64.sv | 70 +++++++
 rtl/twiddle_mult_stage.sv | 108 ++++++++++
 tb/tb_twiddle_mult_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants, payload types and the Q1.14 round/saturate helper.
package fft_pkg;

  localparam int unsigned DW         = 16;
  localparam int unsigned TW         = 16;
  localparam int unsigned FRAC_SHIFT = 14;
  localparam int unsigned ROUND_C    = 1 << 13;
  localparam int unsigned N          = 64;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned ADDR_W     = IDX_W - 1;
  localparam int unsigned PROD_W     = DW + TW;
  localparam int unsigned SUM_W      = DW + TW + 1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  typedef struct packed {
    logic signed [TW-1:0] c;
    logic signed [TW-1:0] d;
  } twiddle_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] ac;
    logic signed [PROD_W-1:0] bd;
    logic signed [PROD_W-1:0] ad;
    logic signed [PROD_W-1:0] bc;
  } prod_t;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DW - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  // Round half-up, drop the Q1.14 fraction, clip to the sample range.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] r;
    r = (x + $signed(SUM_W'(ROUND_C))) >>> FRAC_SHIFT;
    if (r > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end
    return r[DW-1:0];
  endfunction

endpackage

// File: rtl/twiddle_rom_64.sv
// W64^e twiddle table for e = 0..31 in Q1.14, registered one-cycle read.
module twiddle_rom_64
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output twiddle_t          tw
);

  twiddle_t tw_d;
  twiddle_t tw_q;

  function automatic twiddle_t ent(input int c, input int d);
    twiddle_t t;
    t.c = TW'(c);
    t.d = TW'(d);
    return t;
  endfunction

  // c = round(16384*cos(2*pi*e/64)), d = round(-16384*sin(2*pi*e/64))
  always_comb begin
    tw_d = ent(16384, 0);
    case (addr)
      5'd0:  tw_d = ent( 16384,      0);
      5'd1:  tw_d = ent( 16305,  -1606);
      5'd2:  tw_d = ent( 16069,  -3196);
      5'd3:  tw_d = ent( 15679,  -4756);
      5'd4:  tw_d = ent( 15137,  -6270);
      5'd5:  tw_d = ent( 14449,  -7723);
      5'd6:  tw_d = ent( 13623,  -9102);
      5'd7:  tw_d = ent( 12665, -10394);
      5'd8:  tw_d = ent( 11585, -11585);
      5'd9:  tw_d = ent( 10394, -12665);
      5'd10: tw_d = ent(  9102, -13623);
      5'd11: tw_d = ent(  7723, -14449);
      5'd12: tw_d = ent(  6270, -15137);
      5'd13: tw_d = ent(  4756, -15679);
      5'd14: tw_d = ent(  3196, -16069);
      5'd15: tw_d = ent(  1606, -16305);
      5'd16: tw_d = ent(     0, -16384);
      5'd17: tw_d = ent( -1606, -16305);
      5'd18: tw_d = ent( -3196, -16069);
      5'd19: tw_d = ent( -4756, -15679);
      5'd20: tw_d = ent( -6270, -15137);
      5'd21: tw_d = ent( -7723, -14449);
      5'd22: tw_d = ent( -9102, -13623);
      5'd23: tw_d = ent(-10394, -12665);
      5'd24: tw_d = ent(-11585, -11585);
      5'd25: tw_d = ent(-12665, -10394);
      5'd26: tw_d = ent(-13623,  -9102);
      5'd27: tw_d = ent(-14449,  -7723);
      5'd28: tw_d = ent(-15137,  -6270);
      5'd29: tw_d = ent(-15679,  -4756);
      5'd30: tw_d = ent(-16069,  -3196);
      5'd31: tw_d = ent(-16305,  -1606);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_q <= '0;
    end else begin
      tw_q <= tw_d;
    end
  end

  assign tw = tw_q;

endmodule

// File: rtl/twiddle_mult_stage.sv
// Inter-stage complex twiddle multiplier for the 64-point FFT, fixed 3-cycle pipeline.
module twiddle_mult_stage
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [IDX_W-1:0] cnt_mult,
  input  logic [DW-1:0]    din_re,
  input  logic [DW-1:0]    din_im,
  output logic             dout_valid,
  output logic [IDX_W-1:0] dout_idx,
  output logic [DW-1:0]    dout_re,
  output logic [DW-1:0]    dout_im,
  output logic             frame_done
);

  logic [ADDR_W-1:0]       rom_addr_c;
  twiddle_t                tw;

  sample_t                 s1_smp_d,   s1_smp_q;
  logic [IDX_W-1:0]        s1_idx_d,   s1_idx_q;
  logic                    s1_valid_d, s1_valid_q;

  prod_t                   s2_prod_d,  s2_prod_q;
  logic [IDX_W-1:0]        s2_idx_d,   s2_idx_q;
  logic                    s2_valid_d, s2_valid_q;

  logic signed [SUM_W-1:0] re_sum_c,   im_sum_c;
  logic signed [DW-1:0]    dout_re_d,  dout_re_q;
  logic signed [DW-1:0]    dout_im_d,  dout_im_q;
  logic [IDX_W-1:0]        dout_idx_d, dout_idx_q;
  logic                    dout_valid_d, dout_valid_q;
  logic                    frame_done_d, frame_done_q;

  // Only the upper half-frame is rotated; the lower half uses W^0.
  assign rom_addr_c = cnt_mult[IDX_W-1] ? cnt_mult[ADDR_W-1:0] : '0;

  twiddle_rom_64 u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (rom_addr_c),
    .tw    (tw)
  );

  always_comb begin
    s1_smp_d     = '{re: din_re, im: din_im};
    s1_idx_d     = cnt_mult;
    s1_valid_d   = din_valid;

    s2_prod_d.ac = PROD_W'(s1_smp_q.re) * PROD_W'(tw.c);
    s2_prod_d.bd = PROD_W'(s1_smp_q.im) * PROD_W'(tw.d);
    s2_prod_d.ad = PROD_W'(s1_smp_q.re) * PROD_W'(tw.d);
    s2_prod_d.bc = PROD_W'(s1_smp_q.im) * PROD_W'(tw.c);
    s2_idx_d     = s1_idx_q;
    s2_valid_d   = s1_valid_q;

    re_sum_c     = SUM_W'(s2_prod_q.ac) - SUM_W'(s2_prod_q.bd);
    im_sum_c     = SUM_W'(s2_prod_q.ad) + SUM_W'(s2_prod_q.bc);

    // Output data and index hold through bubbles.
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    dout_idx_d   = dout_idx_q;
    dout_valid_d = s2_valid_q;
    frame_done_d = s2_valid_q && (s2_idx_q == IDX_W'(N - 1));
    if (s2_valid_q) begin
      dout_re_d  = round_sat(re_sum_c);
      dout_im_d  = round_sat(im_sum_c);
      dout_idx_d = s2_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_smp_q     <= '0;
      s1_idx_q     <= '0;
      s1_valid_q   <= 1'b0;
      s2_prod_q    <= '0;
      s2_idx_q     <= '0;
      s2_valid_q   <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      s1_smp_q     <= s1_smp_d;
      s1_idx_q     <= s1_idx_d;
      s1_valid_q   <= s1_valid_d;
      s2_prod_q    <= s2_prod_d;
      s2_idx_q     <= s2_idx_d;
      s2_valid_q   <= s2_valid_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      dout_idx_q   <= dout_idx_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_idx   = dout_idx_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Self-checking bench for twiddle_mult_stage: directed vector table, random traffic
// against a real-arithmetic reference model, full-frame and mid-frame reset sequences.
module tb_twiddle_mult_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [5:0]  cnt_mult = '0;
  logic [15:0] din_re = '0;
  logic [15:0] din_im = '0;
  logic        dout_valid;
  logic [5:0]  dout_idx;
  logic [15:0] dout_re;
  logic [15:0] dout_im;
  logic        frame_done;

  always #5 clk = ~clk;

  twiddle_mult_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .cnt_mult   (cnt_mult),
    .din_re     (din_re),
    .din_im     (din_im),
    .dout_valid (dout_valid),
    .dout_idx   (dout_idx),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: twiddle from cos/sin, exact products, round half-up, clip.
  function automatic int rnd(input real x);
    return int'($floor(x + 0.5));
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void ref_rot(input int idx, input int a, input int b,
                                  output int yr, output int yi);
    int     e;
    real    ang;
    longint c, d, xr, xi;
    e   = (idx >= 32) ? idx - 32 : 0;
    ang = 2.0 * 3.14159265358979323846 * real'(e) / 64.0;
    c   = longint'(rnd(16384.0 * $cos(ang)));
    d   = longint'(rnd(-16384.0 * $sin(ang)));
    xr  = longint'(a) * c - longint'(b) * d;
    xi  = longint'(a) * d + longint'(b) * c;
    yr  = sat16(rnd(real'(xr) / 16384.0));
    yi  = sat16(rnd(real'(xi) / 16384.0));
  endfunction

  typedef struct {
    logic       valid;
    logic [5:0] idx;
    int         re;
    int         im;
  } rec_t;

  typedef struct {
    logic       valid;
    logic       fd;
    logic [5:0] idx;
    int         re;
    int         im;
  } exp_t;

  function automatic exp_t next_exp(input exp_t cur, input rec_t r);
    exp_t n;
    n       = cur;
    n.valid = r.valid;
    n.fd    = r.valid && (r.idx == 6'd63);
    if (r.valid) begin
      n.idx = r.idx;
      ref_rot(int'(r.idx), r.re, r.im, n.re, n.im);
    end
    return n;
  endfunction

  rec_t mq[$];
  exp_t exp_s = '{1'b0, 1'b0, 6'd0, 0, 0};
  logic chk_en = 1'b0;

  // Model: what is presented in a cycle shows at dout three cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_s <= '{1'b0, 1'b0, 6'd0, 0, 0};
    end else begin
      if (mq.size() == 2) begin
        exp_s <= next_exp(exp_s, mq[0]);
        void'(mq.pop_front());
      end
      mq.push_back('{din_valid, cnt_mult, int'($signed(din_re)), int'($signed(din_im))});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", longint'(dout_valid), longint'(exp_s.valid));
      chk("model_frame_done", longint'(frame_done), longint'(exp_s.fd));
      chk("model_idx", longint'(dout_idx), longint'(exp_s.idx));
      chk("model_re", longint'($signed(dout_re)), longint'(exp_s.re));
      chk("model_im", longint'($signed(dout_im)), longint'(exp_s.im));
    end
  end

  logic mon_en = 1'b0;
  int   mon_next = 0;
  int   valid_cnt = 0;
  int   fd_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid) begin
        chk("frame_order", longint'(dout_idx), longint'(mon_next));
        mon_next  <= (mon_next + 1) % 64;
        valid_cnt <= valid_cnt + 1;
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        chk("frame_done_idx", longint'(dout_idx), 63);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input int idx);
    din_valid = v;
    cnt_mult  = 6'(idx);
    din_re    = rand_data();
    din_im    = rand_data();
  endtask

  typedef struct {
    int idx;
    int re;
    int im;
    int er;
    int ei;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{ 5,   1000,  -2000,   1000,  -2000};
    vt[1] = '{48,   1000,      0,      0,  -1000};
    vt[2] = '{40,  10000,      0,   7071,  -7071};
    vt[3] = '{48, -32768, -32768, -32768,  32767};
    vt[4] = '{40,      1,      0,      1,     -1};
    vt[5] = '{40,     -1,      0,     -1,      1};
    vt[6] = '{32,  12345,   -321,  12345,   -321};
    vt[7] = '{31,     -7,      9,     -7,      9};
    vt[8] = '{63,  16384,      0, -16305,  -1606};
    vt[9] = '{33,      0,  16384,   1606,  16305};

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), int'($urandom_range(0, 63)));
      tick();
    end
    chk("rst_valid", longint'(dout_valid), 0);
    chk("rst_idx", longint'(dout_idx), 0);
    chk("rst_re", longint'(dout_re), 0);
    chk("rst_im", longint'(dout_im), 0);
    chk("rst_frame_done", longint'(frame_done), 0);
    din_valid = 1'b0;
    chk_en    = 1'b1;
    rst_n     = 1'b1;
    repeat (4) tick();
    chk("idle_valid", longint'(dout_valid), 0);
    chk("idle_re", longint'(dout_re), 0);

    // Directed vectors, one isolated sample each
    for (int k = 0; k < 10; k++) begin
      din_valid = 1'b1;
      cnt_mult  = 6'(vt[k].idx);
      din_re    = 16'(vt[k].re);
      din_im    = 16'(vt[k].im);
      tick();
      din_valid = 1'b0;
      tick();
      chk("vec_early_valid", longint'(dout_valid), 0);
      tick();
      chk("vec_valid", longint'(dout_valid), 1);
      chk("vec_idx", longint'(dout_idx), longint'(vt[k].idx));
      chk("vec_re", longint'($signed(dout_re)), longint'(vt[k].er));
      chk("vec_im", longint'($signed(dout_im)), longint'(vt[k].ei));
      chk("vec_frame_done", longint'(frame_done), (vt[k].idx == 63) ? 1 : 0);
      tick();
      chk("vec_bubble_valid", longint'(dout_valid), 0);
      chk("vec_hold_re", longint'($signed(dout_re)), longint'(vt[k].er));
      chk("vec_hold_idx", longint'(dout_idx), longint'(vt[k].idx));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 8), int'($urandom_range(0, 63)));
      tick();
    end
    din_valid = 1'b0;
    repeat (4) tick();

    // Two full frames, bubble before idx 20 in each
    mon_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) begin
        if (i == 20) begin
          din_valid = 1'b0;
          tick();
        end
        drive(1'b1, i);
        tick();
      end
    end
    din_valid = 1'b0;
    repeat (4) tick();
    chk("frame_valid_count", longint'(valid_cnt), 128);
    chk("frame_done_count", longint'(fd_cnt), 2);

    // Third frame, reset pulsed while idx 30 is in flight
    for (int i = 0; i <= 30; i++) begin
      drive(1'b1, i);
      tick();
    end
    #3;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #2;
    chk("midrst_valid", longint'(dout_valid), 0);
    chk("midrst_re", longint'(dout_re), 0);
    #8;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("flush_valid", longint'(dout_valid), 0);
    chk("flush_idx", longint'(dout_idx), 0);
    chk("flush_frame_done_count", longint'(fd_cnt), 2);
    mon_en = 1'b0;

    // First sample after reset release
    din_valid = 1'b1;
    cnt_mult  = 6'd5;
    din_re    = 16'(1000);
    din_im    = 16'(-2000);
    tick();
    din_valid = 1'b0;
    chk("post_rst_lat1", longint'(dout_valid), 0);
    tick();
    chk("post_rst_lat2", longint'(dout_valid), 0);
    tick();
    chk("post_rst_valid", longint'(dout_valid), 1);
    chk("post_rst_re", longint'($signed(dout_re)), 1000);
    chk("post_rst_im", longint'($signed(dout_im)), -2000);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
